// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Lets two requesters share one combinational RV32 ALU. Requester 0 is the
// integer issue path and requester 1 is the branch/address unit. A
// round-robin arbiter picks one request and captures its operands and opcode.
// The captured values drive the ALU for EXEC_CYCLES cycles. The ALU result
// and flags are then registered and returned on a valid/ready response
// channel, tagged with the id of the requester that issued the op. An opcode
// outside 0..NUM_OPS-1 does not use the ALU. It goes straight to the response
// state with rsp_err_o set.
//
// Parameters
//   WIDTH        operand/result width (32)
//   EXEC_CYCLES  cycles the ALU inputs are held before capture (1..4)
//   NUM_OPS      number of legal ALU control codes (10)
//
// Ports
//   clk_i, reset_i                 clock, synchronous active-high reset
//   reqN_valid_i / reqN_ready_o    request handshake, requester N (0/1)
//   reqN_rs1_i, reqN_rs2_i         request operands
//   reqN_ctrl_i                    request ALUControl code
//   alu_rs1_o, alu_rs2_o           operands to the shared ALU
//   alu_ctrl_o                     ALUControl to the shared ALU
//   alu_out_i, alu_zero_i,
//   alu_negative_i                 ALU result and flags
//   rsp_valid_o / rsp_ready_i      response handshake
//   rsp_id_o                       requester that issued the op
//   rsp_result_o, rsp_zero_o,
//   rsp_negative_o                 captured ALU result and flags
//   rsp_err_o                      opcode was illegal
//
// Optional build macro ALU_ARB_STATS_EN adds these outputs:
//   stat_grant0_o, stat_grant1_o   handshakes per requester (saturating)
//   stat_stall_o                   response cycles with rsp_ready_i low
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int WIDTH       = 32,
    parameter int EXEC_CYCLES = 1,
    parameter int NUM_OPS     = 10
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_rs1_i,
    input  logic [WIDTH-1:0] req0_rs2_i,
    input  logic [3:0]       req0_ctrl_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_rs1_i,
    input  logic [WIDTH-1:0] req1_rs2_i,
    input  logic [3:0]       req1_ctrl_i,
    output logic [WIDTH-1:0] alu_rs1_o,
    output logic [WIDTH-1:0] alu_rs2_o,
    output logic [3:0]       alu_ctrl_o,
    input  logic [WIDTH-1:0] alu_out_i,
    input  logic             alu_zero_i,
    input  logic             alu_negative_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic             rsp_zero_o,
    output logic             rsp_negative_o,
    output logic             rsp_err_o
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]      stat_grant0_o,
    output logic [31:0]      stat_grant1_o,
    output logic [31:0]      stat_stall_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(EXEC_CYCLES - 1);

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_id_q, op_id_d;
    logic [WIDTH-1:0] alu_rs1_q, alu_rs1_d;
    logic [WIDTH-1:0] alu_rs2_q, alu_rs2_d;
    logic [3:0]       alu_ctrl_q, alu_ctrl_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_negative_q, rsp_negative_d;
    logic             rsp_err_q, rsp_err_d;

    logic             grant0, grant1;
    logic             hs_any, hs1;
    logic [WIDTH-1:0] sel_rs1, sel_rs2;
    logic [3:0]       sel_ctrl;
    logic             sel_illegal;
    logic             last_exec;

    // rr_q set means requester 1 holds priority when both are valid.
    always_comb begin
        grant0 = req0_valid_i & (~req1_valid_i | ~rr_q);
        grant1 = req1_valid_i & (~req0_valid_i | rr_q);
    end

    // A ready only ever accompanies a matching valid, so the readys are the handshakes.
    always_comb begin
        hs1         = req1_ready_o;
        hs_any      = req0_ready_o | req1_ready_o;
        sel_rs1     = hs1 ? req1_rs1_i  : req0_rs1_i;
        sel_rs2     = hs1 ? req1_rs2_i  : req0_rs2_i;
        sel_ctrl    = hs1 ? req1_ctrl_i : req0_ctrl_i;
        sel_illegal = ({1'b0, sel_ctrl} >= 5'(NUM_OPS));
        last_exec   = (cnt_q == LAST_CNT);
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (hs_any) state_d = sel_illegal ? RESP : EXEC;
            EXEC: if (last_exec) state_d = RESP;
            RESP: if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic. The readys are gated by reset so that no handshake appears to complete on a reset edge.
    always_comb begin
        req0_ready_o = (state_q == IDLE) & ~reset_i & grant0;
        req1_ready_o = (state_q == IDLE) & ~reset_i & grant1;
        rsp_valid_o  = (state_q == RESP);
    end

    // Datapath next-state logic. An illegal op leaves the ALU inputs untouched.
    always_comb begin
        rr_d           = rr_q;
        cnt_d          = '0;
        op_id_d        = op_id_q;
        alu_rs1_d      = alu_rs1_q;
        alu_rs2_d      = alu_rs2_q;
        alu_ctrl_d     = alu_ctrl_q;
        rsp_id_d       = rsp_id_q;
        rsp_result_d   = rsp_result_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_negative_d = rsp_negative_q;
        rsp_err_d      = rsp_err_q;
        if (hs_any) begin
            rr_d    = ~hs1;
            op_id_d = hs1;
            if (sel_illegal) begin
                rsp_id_d       = hs1;
                rsp_result_d   = '0;
                rsp_zero_d     = 1'b0;
                rsp_negative_d = 1'b0;
                rsp_err_d      = 1'b1;
            end else begin
                alu_rs1_d  = sel_rs1;
                alu_rs2_d  = sel_rs2;
                alu_ctrl_d = sel_ctrl;
            end
        end
        if (state_q == EXEC) begin
            if (last_exec) begin
                rsp_id_d       = op_id_q;
                rsp_result_d   = alu_out_i;
                rsp_zero_d     = alu_zero_i;
                rsp_negative_d = alu_negative_i;
                rsp_err_d      = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_q           <= 1'b0;
            cnt_q          <= '0;
            op_id_q        <= 1'b0;
            alu_rs1_q      <= '0;
            alu_rs2_q      <= '0;
            alu_ctrl_q     <= '0;
            rsp_id_q       <= 1'b0;
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_negative_q <= 1'b0;
            rsp_err_q      <= 1'b0;
        end else begin
            rr_q           <= rr_d;
            cnt_q          <= cnt_d;
            op_id_q        <= op_id_d;
            alu_rs1_q      <= alu_rs1_d;
            alu_rs2_q      <= alu_rs2_d;
            alu_ctrl_q     <= alu_ctrl_d;
            rsp_id_q       <= rsp_id_d;
            rsp_result_q   <= rsp_result_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_negative_q <= rsp_negative_d;
            rsp_err_q      <= rsp_err_d;
        end
    end

    assign alu_rs1_o      = alu_rs1_q;
    assign alu_rs2_o      = alu_rs2_q;
    assign alu_ctrl_o     = alu_ctrl_q;
    assign rsp_id_o       = rsp_id_q;
    assign rsp_result_o   = rsp_result_q;
    assign rsp_zero_o     = rsp_zero_q;
    assign rsp_negative_o = rsp_negative_q;
    assign rsp_err_o      = rsp_err_q;

`ifdef ALU_ARB_STATS_EN
    logic [31:0] stat_grant0_q, stat_grant0_d;
    logic [31:0] stat_grant1_q, stat_grant1_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Saturating event counters.
    always_comb begin
        stat_grant0_d = stat_grant0_q;
        stat_grant1_d = stat_grant1_q;
        stat_stall_d  = stat_stall_q;
        if (req0_ready_o && (stat_grant0_q != 32'hFFFF_FFFF)) stat_grant0_d = stat_grant0_q + 32'd1;
        if (req1_ready_o && (stat_grant1_q != 32'hFFFF_FFFF)) stat_grant1_d = stat_grant1_q + 32'd1;
        if ((state_q == RESP) && !rsp_ready_i && (stat_stall_q != 32'hFFFF_FFFF))
            stat_stall_d = stat_stall_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_grant0_q <= '0;
            stat_grant1_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_grant0_q <= stat_grant0_d;
            stat_grant1_q <= stat_grant1_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_grant0_o = stat_grant0_q;
    assign stat_grant1_o = stat_grant1_q;
    assign stat_stall_o  = stat_stall_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Drives two arbiters from the same request and response inputs:
//   dut 0 is built with EXEC_CYCLES=1.
//   dut 1 is built with EXEC_CYCLES=3.
// Each dut drives its own behavioural RV32 ALU stand-in.
//
// A transaction-level model of each arbiter tracks these quantities:
//   - the busy/idle state
//   - the round-robin priority
//   - the age of the outstanding op
//   - the expected response
// The model is compared against both duts on every falling edge.
//
// Directed scenarios add literal expectations on top of the model.
//
// Build with ALU_ARB_STATS_EN defined to also exercise the statistics outputs.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int NUM_OPS = 10;
    localparam int EC0     = 1;
    localparam int EC1     = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0Valid, req1Valid, rspReady;
    logic [31:0] req0Rs1, req0Rs2, req1Rs1, req1Rs2;
    logic [3:0]  req0Ctrl, req1Ctrl;

    logic        rdy0 [2];
    logic        rdy1 [2];
    logic        rspValid [2];
    logic        rspId [2];
    logic        rspZero [2];
    logic        rspNeg [2];
    logic        rspErr [2];
    logic [31:0] rspResult [2];
    logic [31:0] aluA [2];
    logic [31:0] aluB [2];
    logic [3:0]  aluCtrl [2];
    logic [31:0] aluOut [2];
    logic        aluZero [2];
    logic        aluNeg [2];
`ifdef ALU_ARB_STATS_EN
    logic [31:0] statG0 [2];
    logic [31:0] statG1 [2];
    logic [31:0] statStall [2];
`endif

    int checks   = 0;
    int failures = 0;

    // Model state, one entry per dut.
    int          mEc [2];
    logic        mBusy [2];
    int          mAge [2];
    int          mLat [2];
    logic        mFavor1 [2];
    logic        mPost [2];
    logic [31:0] mRes [2];
    logic        mZero [2];
    logic        mNeg [2];
    logic        mErr [2];
    logic        mId [2];
    logic [31:0] mA [2];
    logic [31:0] mB [2];
    logic [3:0]  mC [2];
    int          mG0 [2];
    int          mG1 [2];
    int          mStall [2];
    logic        modelOn = 1'b0;

    always #5 clk = ~clk;

    // Reference RV32 ALU behaviour for codes 0..9.
    function automatic logic [31:0] aluFn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (c)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = {31'b0, $signed(a) < $signed(b)};
            4'd6: r = {31'b0, a < b};
            4'd7: r = a << b[4:0];
            4'd8: r = a >> b[4:0];
            4'd9: r = $unsigned($signed(a) >>> b[4:0]);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign aluOut[0]  = aluFn(aluCtrl[0], aluA[0], aluB[0]);
    assign aluOut[1]  = aluFn(aluCtrl[1], aluA[1], aluB[1]);
    assign aluZero[0] = (aluOut[0] == 32'd0);
    assign aluZero[1] = (aluOut[1] == 32'd0);
    assign aluNeg[0]  = aluOut[0][31];
    assign aluNeg[1]  = aluOut[1][31];

    alu_share_arbiter #(.WIDTH(32), .EXEC_CYCLES(EC0), .NUM_OPS(NUM_OPS)) dut0 (
        .clk_i(clk), .reset_i(reset),
        .req0_valid_i(req0Valid), .req0_ready_o(rdy0[0]),
        .req0_rs1_i(req0Rs1), .req0_rs2_i(req0Rs2), .req0_ctrl_i(req0Ctrl),
        .req1_valid_i(req1Valid), .req1_ready_o(rdy1[0]),
        .req1_rs1_i(req1Rs1), .req1_rs2_i(req1Rs2), .req1_ctrl_i(req1Ctrl),
        .alu_rs1_o(aluA[0]), .alu_rs2_o(aluB[0]), .alu_ctrl_o(aluCtrl[0]),
        .alu_out_i(aluOut[0]), .alu_zero_i(aluZero[0]), .alu_negative_i(aluNeg[0]),
        .rsp_valid_o(rspValid[0]), .rsp_ready_i(rspReady), .rsp_id_o(rspId[0]),
        .rsp_result_o(rspResult[0]), .rsp_zero_o(rspZero[0]),
        .rsp_negative_o(rspNeg[0]), .rsp_err_o(rspErr[0])
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_grant0_o(statG0[0]), .stat_grant1_o(statG1[0]), .stat_stall_o(statStall[0])
`endif
    );

    alu_share_arbiter #(.WIDTH(32), .EXEC_CYCLES(EC1), .NUM_OPS(NUM_OPS)) dut1 (
        .clk_i(clk), .reset_i(reset),
        .req0_valid_i(req0Valid), .req0_ready_o(rdy0[1]),
        .req0_rs1_i(req0Rs1), .req0_rs2_i(req0Rs2), .req0_ctrl_i(req0Ctrl),
        .req1_valid_i(req1Valid), .req1_ready_o(rdy1[1]),
        .req1_rs1_i(req1Rs1), .req1_rs2_i(req1Rs2), .req1_ctrl_i(req1Ctrl),
        .alu_rs1_o(aluA[1]), .alu_rs2_o(aluB[1]), .alu_ctrl_o(aluCtrl[1]),
        .alu_out_i(aluOut[1]), .alu_zero_i(aluZero[1]), .alu_negative_i(aluNeg[1]),
        .rsp_valid_o(rspValid[1]), .rsp_ready_i(rspReady), .rsp_id_o(rspId[1]),
        .rsp_result_o(rspResult[1]), .rsp_zero_o(rspZero[1]),
        .rsp_negative_o(rspNeg[1]), .rsp_err_o(rspErr[1])
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_grant0_o(statG0[1]), .stat_grant1_o(statG1[1]), .stat_stall_o(statStall[1])
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of request/response inputs just after the rising edge.
    task automatic applyStimulus(input logic v0, input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic v1, input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                                 input logic rr);
        @(posedge clk);
        #1;
        req0Valid = v0; req0Ctrl = c0; req0Rs1 = a0; req0Rs2 = b0;
        req1Valid = v1; req1Ctrl = c1; req1Rs1 = a1; req1Rs2 = b1;
        rspReady  = rr;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One model step for dut d: compare the current outputs, then advance to the next cycle.
    task automatic modelCycle(input int d);
        logic        e0, e1, ev;
        logic [31:0] a, b;
        logic [3:0]  c;
        e0 = !reset && !mBusy[d] && req0Valid && (!req1Valid || !mFavor1[d]);
        e1 = !reset && !mBusy[d] && req1Valid && (!req0Valid || mFavor1[d]);
        ev = mBusy[d] && (mAge[d] >= mLat[d]);
        if (modelOn) begin
            checkOutput($sformatf("dut%0d ready0", d), 32'(rdy0[d]), 32'(e0));
            checkOutput($sformatf("dut%0d ready1", d), 32'(rdy1[d]), 32'(e1));
            checkOutput($sformatf("dut%0d rsp_valid", d), 32'(rspValid[d]), 32'(ev));
            if (ev || mPost[d]) begin
                checkOutput($sformatf("dut%0d rsp_result", d), rspResult[d], mRes[d]);
                checkOutput($sformatf("dut%0d rsp_id", d), 32'(rspId[d]), 32'(mId[d]));
                checkOutput($sformatf("dut%0d rsp_zero", d), 32'(rspZero[d]), 32'(mZero[d]));
                checkOutput($sformatf("dut%0d rsp_neg", d), 32'(rspNeg[d]), 32'(mNeg[d]));
                checkOutput($sformatf("dut%0d rsp_err", d), 32'(rspErr[d]), 32'(mErr[d]));
            end
            checkOutput($sformatf("dut%0d alu_rs1", d), aluA[d], mA[d]);
            checkOutput($sformatf("dut%0d alu_rs2", d), aluB[d], mB[d]);
            checkOutput($sformatf("dut%0d alu_ctrl", d), 32'(aluCtrl[d]), 32'(mC[d]));
`ifdef ALU_ARB_STATS_EN
            checkOutput($sformatf("dut%0d stat_grant0", d), statG0[d], mG0[d]);
            checkOutput($sformatf("dut%0d stat_grant1", d), statG1[d], mG1[d]);
            checkOutput($sformatf("dut%0d stat_stall", d), statStall[d], mStall[d]);
`endif
        end
        if (reset) begin
            mBusy[d] = 0; mAge[d] = 0; mLat[d] = 0; mFavor1[d] = 0; mPost[d] = 1;
            mRes[d] = 0; mZero[d] = 0; mNeg[d] = 0; mErr[d] = 0; mId[d] = 0;
            mA[d] = 0; mB[d] = 0; mC[d] = 0;
            mG0[d] = 0; mG1[d] = 0; mStall[d] = 0;
        end else begin
            if (ev && !rspReady) mStall[d]++;
            if (e0 || e1) begin
                a = e1 ? req1Rs1 : req0Rs1;
                b = e1 ? req1Rs2 : req0Rs2;
                c = e1 ? req1Ctrl : req0Ctrl;
                if (e0) mG0[d]++; else mG1[d]++;
                mId[d] = e1; mFavor1[d] = e0; mBusy[d] = 1; mAge[d] = 1; mPost[d] = 0;
                if (int'(c) < NUM_OPS) begin
                    mRes[d] = aluFn(c, a, b);
                    mZero[d] = (mRes[d] == 32'd0);
                    mNeg[d] = mRes[d][31];
                    mErr[d] = 0;
                    mLat[d] = 1 + mEc[d];
                    mA[d] = a; mB[d] = b; mC[d] = c;
                end else begin
                    mRes[d] = 0; mZero[d] = 0; mNeg[d] = 0; mErr[d] = 1;
                    mLat[d] = 1;
                end
            end else if (mBusy[d]) begin
                if (ev && rspReady) mBusy[d] = 0;
                else mAge[d]++;
            end
        end
    endtask

    task automatic compareLoop();
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) modelCycle(d);
            if (reset) modelOn = 1'b1;
        end
    endtask

    initial begin
        int order [6];
        int grants;
        int cyc;

        mEc[0] = EC0;
        mEc[1] = EC1;
        reset = 1'b1;
        req0Valid = 1'b1; req0Ctrl = 4'd0; req0Rs1 = 32'd0; req0Rs2 = 32'd0;
        req1Valid = 1'b1; req1Ctrl = 4'd0; req1Rs1 = 32'd0; req1Rs2 = 32'd0;
        rspReady = 1'b0;

        fork
            compareLoop();
            begin
                #200000;
                $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
                $fatal(1, "[TB] watchdog");
            end
        join_none

        // Reset with both valids high: no readys, all outputs zero.
        tick();
        tick();
        @(negedge clk);
        checkOutput("reset ready0", 32'(rdy0[0]), 32'd0);
        checkOutput("reset ready1", 32'(rdy1[0]), 32'd0);
        checkOutput("reset rsp_valid", 32'(rspValid[0]), 32'd0);
        checkOutput("reset rsp_result", rspResult[0], 32'd0);
        checkOutput("reset alu_ctrl", 32'(aluCtrl[0]), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        rspReady = 1'b1;
        idleCycles(2);

        // ADD 5+10 from requester 0, response two cycles after the handshake.
        applyStimulus(1, 4'd0, 32'd5, 32'd10, 0, 4'd0, 0, 0, 1'b1);
        @(negedge clk);
        checkOutput("add ready0", 32'(rdy0[0]), 32'd1);
        applyStimulus(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1'b1);
        @(negedge clk);
        checkOutput("add not yet valid", 32'(rspValid[0]), 32'd0);
        checkOutput("add alu_rs1", aluA[0], 32'd5);
        tick();
        @(negedge clk);
        checkOutput("add rsp_valid", 32'(rspValid[0]), 32'd1);
        checkOutput("add result", rspResult[0], 32'd15);
        checkOutput("add id", 32'(rspId[0]), 32'd0);
        checkOutput("add zero", 32'(rspZero[0]), 32'd0);
        checkOutput("add neg", 32'(rspNeg[0]), 32'd0);
        checkOutput("add err", 32'(rspErr[0]), 32'd0);
        idleCycles(3);

        // SUB 5-10 from requester 1: negative result.
        applyStimulus(0, 4'd0, 0, 0, 1, 4'd1, 32'd5, 32'd10, 1'b1);
        applyStimulus(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1'b1);
        tick();
        @(negedge clk);
        checkOutput("sub result", rspResult[0], 32'hFFFF_FFFB);
        checkOutput("sub neg", 32'(rspNeg[0]), 32'd1);
        checkOutput("sub id", 32'(rspId[0]), 32'd1);
        idleCycles(3);

        // SUB 7-7: zero flag.
        applyStimulus(0, 4'd0, 0, 0, 1, 4'd1, 32'd7, 32'd7, 1'b1);
        applyStimulus(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1'b1);
        tick();
        @(negedge clk);
        checkOutput("sub7 zero", 32'(rspZero[0]), 32'd1);
        checkOutput("sub7 result", rspResult[0], 32'd0);
        idleCycles(6);

        // Both valid continuously: grants alternate 0,1,0,1,0,1 and never two readys at once.
        applyStimulus(1, 4'd4, 32'h0F0F, 32'h00FF, 1, 4'd3, 32'h1000, 32'h0001, 1'b1);
        grants = 0;
        cyc = 0;
        while (grants < 6 && cyc < 40) begin
            @(negedge clk);
            checkOutput("single ready", 32'(rdy0[0] & rdy1[0]), 32'd0);
            if (rdy0[0]) begin order[grants] = 0; grants++; end
            else if (rdy1[0]) begin order[grants] = 1; grants++; end
            tick();
            cyc++;
        end
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        if (grants < 6) checkOutput("grant count timeout", grants, 6);
        for (int i = 0; i < grants; i++) checkOutput($sformatf("grant order %0d", i), order[i], i % 2);
        idleCycles(6);

        // Illegal opcode: error response next cycle, ALU inputs keep the last legal op (OR 0x1000,1).
        applyStimulus(1, 4'b1010, 32'd3, 32'd4, 0, 4'd0, 0, 0, 1'b1);
        @(negedge clk);
        checkOutput("illegal ready0", 32'(rdy0[0]), 32'd1);
        applyStimulus(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1'b1);
        @(negedge clk);
        checkOutput("illegal rsp_valid", 32'(rspValid[0]), 32'd1);
        checkOutput("illegal err", 32'(rspErr[0]), 32'd1);
        checkOutput("illegal result", rspResult[0], 32'd0);
        checkOutput("illegal id", 32'(rspId[0]), 32'd0);
        checkOutput("illegal alu_ctrl held", 32'(aluCtrl[0]), 32'd3);
        checkOutput("illegal alu_rs1 held", aluA[0], 32'h1000);
        idleCycles(6);

        // Consumer stalls five response cycles while requester 0 waits.
        applyStimulus(0, 4'd0, 0, 0, 1, 4'd0, 32'd1, 32'd2, 1'b0);
        @(negedge clk);
        checkOutput("stall ready1", 32'(rdy1[0]), 32'd1);
        applyStimulus(1, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1'b0);
        @(negedge clk);
        checkOutput("stall exec", 32'(rspValid[0]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            checkOutput("stall rsp_valid", 32'(rspValid[0]), 32'd1);
            checkOutput("stall result held", rspResult[0], 32'd3);
            checkOutput("stall id held", 32'(rspId[0]), 32'd1);
            checkOutput("stall ready0", 32'(rdy0[0]), 32'd0);
        end
        applyStimulus(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1'b1);
        @(negedge clk);
        checkOutput("stall release valid", 32'(rspValid[0]), 32'd1);
        tick();
        @(negedge clk);
        checkOutput("stall done", 32'(rspValid[0]), 32'd0);
`ifdef ALU_ARB_STATS_EN
        checkOutput("stat_stall", statStall[0], 32'd5);
        checkOutput("stat_grant0", statG0[0], 32'd5);
        checkOutput("stat_grant1", statG1[0], 32'd6);
`endif
        idleCycles(8);

        // Reset while the EXEC_CYCLES=3 instance is mid-execution: op dropped, outputs cleared.
        applyStimulus(1, 4'd0, 32'd9, 32'd9, 0, 4'd0, 0, 0, 1'b1);
        @(negedge clk);
        checkOutput("rst ready0 dut1", 32'(rdy0[1]), 32'd1);
        applyStimulus(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1'b1);
        @(negedge clk);
        checkOutput("rst exec alu_rs1 dut1", aluA[1], 32'd9);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst rsp_valid dut1", 32'(rspValid[1]), 32'd0);
        checkOutput("rst alu_rs1 dut1", aluA[1], 32'd0);
        checkOutput("rst alu_ctrl dut1", 32'(aluCtrl[1]), 32'd0);
        checkOutput("rst result dut1", rspResult[1], 32'd0);
        checkOutput("rst ready0 after dut1", 32'(rdy0[1]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            checkOutput("rst no response dut1", 32'(rspValid[1]), 32'd0);
        end

        idleCycles(2);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
